// File: rtl/vga_pkg.sv
// vga_pkg: constants shared by the VGA colour-level path.
package vga_pkg;
    localparam int LEVEL_W             = 4;
    localparam int NUM_CH              = 3;
    localparam int CH_R                = 0;
    localparam int CH_G                = 1;
    localparam int CH_B                = 2;
    localparam int DEBOUNCE_CYCLES_DEF = 250000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise, debounce and rising-edge detect one raw push-button.
module btn_debounce
    import vga_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   lvl_q, lvl_d, prev_q, rise_q;
    logic                   s;

    assign s         = sync_q[SYNC_STAGES-1];
    assign btn_level = lvl_q;
    assign btn_rise  = rise_q;

    // any sample equal to the accepted level restarts the stability count
    always_comb begin
        cnt_d = (s == lvl_q || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        lvl_d = (s != lvl_q && cnt_q == CNT_LAST) ? s : lvl_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            cnt_q  <= '0;
            lvl_q  <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
            cnt_q  <= cnt_d;
            lvl_q  <= lvl_d;
            prev_q <= lvl_q;
            rise_q <= lvl_q & ~prev_q;
        end
    end
endmodule

// File: rtl/rgb_level_ctrl.sv
// rgb_level_ctrl: button-driven RGB levels, staged in shadows and committed on frame start.
module rgb_level_ctrl #(
    parameter int DEBOUNCE_CYCLES = vga_pkg::DEBOUNCE_CYCLES_DEF,
    parameter int LEVEL_W         = vga_pkg::LEVEL_W,
    parameter int SYNC_STAGES     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               but_R,
    input  logic               but_G,
    input  logic               but_B,
    input  logic               frame_start,
    output logic [LEVEL_W-1:0] level_r,
    output logic [LEVEL_W-1:0] level_g,
    output logic [LEVEL_W-1:0] level_b,
    output logic [2:0]         press
);
    import vga_pkg::*;

    logic [NUM_CH-1:0]              raw, rise, db_level_unused;
    logic [NUM_CH-1:0][LEVEL_W-1:0] shadow_q, shadow_d, level_q, level_d;

    assign raw[CH_R] = but_R;
    assign raw[CH_G] = but_G;
    assign raw[CH_B] = but_B;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .btn_in   (raw[c]),
            .btn_level(db_level_unused[c]),
            .btn_rise (rise[c])
        );
    end

    // commit reads the pre-increment shadow, so a coincident press lands next frame
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            shadow_d[i] = rise[i] ? shadow_q[i] + 1'b1 : shadow_q[i];
            level_d[i]  = frame_start ? shadow_q[i] : level_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= '0;
            level_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            level_q  <= level_d;
        end
    end

    assign press   = rise;
    assign level_r = level_q[CH_R];
    assign level_g = level_q[CH_G];
    assign level_b = level_q[CH_B];
endmodule

// File: tb/tb_rgb_level_ctrl.sv
// tb_rgb_level_ctrl: directed scoreboard bench for rgb_level_ctrl.
module tb_rgb_level_ctrl;
    logic       clk = 0, rst = 0, but_R = 0, but_G = 0, but_B = 0, frame_start = 0;
    logic [3:0] level_r, level_g, level_b;
    logic [2:0] press;
    int         total = 0, bad = 0, cyc = 0, old;
    int         pcount[3] = '{0, 0, 0};
    int         exp_sh[3] = '{0, 0, 0};
    int         exp_lv[3] = '{0, 0, 0};

    typedef struct {
        int       cyc;
        logic [2:0] mask;
    } exp_t;
    exp_t q[$];

    rgb_level_ctrl #(.DEBOUNCE_CYCLES(4), .LEVEL_W(4), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .but_R(but_R), .but_G(but_G), .but_B(but_B),
        .frame_start(frame_start), .level_r(level_r), .level_g(level_g),
        .level_b(level_b), .press(press)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btn(input int ch, input logic v);
        if (ch == 0) but_R = v;
        else if (ch == 1) but_G = v;
        else but_B = v;
    endtask

    // press is due 7 edges after the input changes at a negedge
    task automatic press_btn(input int ch, input int hold, input int rel);
        set_btn(ch, 1'b1);
        q.push_back('{cyc + 7, 3'(1 << ch)});
        exp_sh[ch] = (exp_sh[ch] + 1) % 16;
        tick(hold);
        set_btn(ch, 1'b0);
        tick(rel);
    endtask

    task automatic check_levels(input string tag);
        check({tag, "_r"}, 32'(level_r), exp_lv[0]);
        check({tag, "_g"}, 32'(level_g), exp_lv[1]);
        check({tag, "_b"}, 32'(level_b), exp_lv[2]);
    endtask

    task automatic frame(input string tag);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        exp_lv = exp_sh;
        check_levels(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_press"}, 32'(press), 0);
        check({tag, "_r"}, 32'(level_r), 0);
        check({tag, "_g"}, 32'(level_g), 0);
        check({tag, "_b"}, 32'(level_b), 0);
    endtask

    always @(negedge clk) begin
        if (press !== 3'b000) begin
            exp_t e;
            for (int i = 0; i < 3; i++) if (press[i]) pcount[i]++;
            if (q.size() == 0) check("press_unexpected", 32'(press), 0);
            else begin
                e = q.pop_front();
                check("press_cycle", cyc, e.cyc);
                check("press_mask", 32'(press), 32'(e.mask));
            end
        end
    end

    initial begin
        #7;
        check_zero("reset");
        tick(2);
        rst = 1'b1;
        press_btn(0, 20, 10);
        check("r_press_once", pcount[0], 1);
        check_levels("uncommitted");
        frame("basic_commit");

        set_btn(1, 1'b1);
        for (int i = 0; i < 15; i++) begin
            tick(2);
            but_G = ~but_G;
        end
        set_btn(1, 1'b0);
        tick(10);
        check("bounce_no_press", pcount[1], 0);
        frame("bounce_commit");

        for (int i = 0; i < 16; i++) press_btn(2, 10, 10);
        check("b_press16", pcount[2], 16);
        frame("wrap_commit");
        press_btn(2, 10, 10);
        frame("wrap_plus1");

        for (int i = 0; i < 3; i++) begin
            press_btn(0, 10, 10);
            check_levels("gated_hold");
        end
        frame("gated_commit");

        old = exp_sh[0];
        set_btn(0, 1'b1);
        q.push_back('{cyc + 7, 3'b001});
        exp_sh[0] = (exp_sh[0] + 1) % 16;
        tick(7);
        check("sim_press", 32'(press), 1);
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        exp_lv = exp_sh;
        exp_lv[0] = old;
        check_levels("sim_old");
        set_btn(0, 1'b0);
        tick(10);
        frame("sim_next");

        set_btn(0, 1'b1);
        tick(4);
        #2 rst = 1'b0;
        #1 check_zero("async_rst");
        tick(2);
        check_zero("in_rst");
        rst = 1'b1;
        pcount[0] = 0;
        exp_sh = '{0, 0, 0};
        exp_lv = '{0, 0, 0};
        q.push_back('{cyc + 7, 3'b001});
        exp_sh[0] = 1;
        tick(20);
        check("rst_press_once", pcount[0], 1);
        set_btn(0, 1'b0);
        tick(10);
        frame("rst_commit");

        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
